memwb_pipe: RTL and testbench
=============================

// Module: memwb_pipe
// PURPOSE
//  Parametrised MEM/WB pipeline register for the 32-bit MIPS datapath: carries WB control,
//  memory read data, ALU result and destination register from MEM to WB over DEPTH clocked
//  stages. Adds valid tracking, stall (hold), flush (bubble insert), $zero write protection
//  and the final MemtoReg write-back mux. Sits between data memory and the register file.
// PARAMETERS
//  DATA_W     32  width of ReadData / ALUresult / WriteData
//  REG_W      5   width of destination register address
//  DEPTH      1   number of register stages MEM->WB (legal 1..4; other values: elaboration error)
//  ZERO_PROT  1   1 = suppress RegWrite when DirWriteReg == 0
// PORTS
//  clk            in   1       rising-edge clock
//  rst            in   1       asynchronous, active-high reset
//  stall          in   1       hold all stages
//  flush          in   1       invalidate all stages
//  i_valid        in   1       MEM-stage instruction valid
//  i_wb           in   2       WB control: [1]=RegWrite, [0]=MemtoReg
//  i_readdata     in   DATA_W  data-memory read data
//  i_aluresult    in   DATA_W  ALU result / address
//  i_dirwritereg  in   REG_W   destination register
//  o_valid        out  1       WB-stage instruction valid
//  o_memtoreg     out  1       WB MemtoReg
//  o_regwrite     out  1       register-file write enable (qualified)
//  o_readdata     out  DATA_W  registered read data
//  o_aluresult    out  DATA_W  registered ALU result
//  o_dirwritereg  out  REG_W   registered destination register
//  o_writedata    out  DATA_W  o_memtoreg ? o_readdata : o_aluresult (combinational from regs)
// BEHAVIOUR
//  - Reset (rst=1, async): every stage valid/RegWrite/MemtoReg=0, data/address fields=0;
//    hence all outputs 0 immediately, independent of clk. Release is synchronous-safe: first
//    capture on the first rising edge with rst=0.
//  - Latency: input sampled at edge N appears on outputs after edge N+DEPTH-1 (i.e. DEPTH edges).
//  - Per rising edge, priority flush > stall > advance:
//    flush=1: all stages valid=0 and RegWrite=0; data fields don't-care (hold); stall ignored.
//    stall=1: every stage holds; inputs not sampled; outputs unchanged.
//    else: stage0 <= inputs, stage k <= stage k-1.
//  - Bubble: a stage with valid=0 always presents RegWrite=0 (captured as i_valid & i_wb[1]).
//  - o_regwrite = last.valid & last.RegWrite & (ZERO_PROT ? last.addr != 0 : 1).
//  - o_writedata never registered separately; changes only when stage registers change.
//  - Simultaneous flush and stall: flush wins, pipeline empties, next edge resumes normally.
//  - rst asserted mid-operation: in-flight instructions discarded, no write issued.
// CONFIGURATION
//  MEMWB_FWD_EN defined: extra ports fwd_rs/fwd_rt (in, REG_W), fwd_hit_rs/fwd_hit_rt (out, 1),
//    fwd_data_rs/fwd_data_rt (out, DATA_W). Combinational search over all DEPTH stages for
//    valid & RegWrite & addr==fwd_rX & addr!=0; youngest matching stage (stage0) wins; data is
//    that stage's muxed write data. No match: hit=0, data=0.
//  MEMWB_FWD_EN undefined: those ports and the search logic are absent.
// TESTING
//  1 rst=1 with nonzero inputs, clk running -> all outputs 0; release, i_wb=2'b10, alu=0x1234,
//    addr=5, valid=1 -> after DEPTH edges o_regwrite=1, o_writedata=0x1234, o_dirwritereg=5.
//  2 i_wb=2'b11, readdata=0xDEADBEEF, alu=0x10 -> o_writedata=0xDEADBEEF, o_memtoreg=1.
//  3 DEPTH=3, stream A,B,C; stall=1 for 2 cycles after B enters -> outputs frozen, order A,B,C,
//    no duplicate or lost instruction.
//  4 flush=1 and stall=1 same edge with 2 valid in flight -> next edge o_valid=0, o_regwrite=0.
//  5 addr=0, i_wb=2'b10, ZERO_PROT=1 -> o_regwrite=0; ZERO_PROT=0 -> o_regwrite=1.
//  6 MEMWB_FWD_EN, DEPTH=2, stage0 addr 7 data 0xA, stage1 addr 7 data 0xB, fwd_rs=7
//    -> fwd_hit_rs=1, fwd_data_rs=0xA; fwd_rt=0 -> fwd_hit_rt=0.

Source files
------------

// File: rtl/memwb_pipe.sv
// memwb_pipe: MEM/WB pipeline register for the 32-bit MIPS datapath.
// Carries WB control, memory read data, ALU result and destination register
// across DEPTH clocked stages. Also provides valid tracking, stall (hold),
// flush (bubble insert), $zero write protection and the MemtoReg write-back mux.
// Optional feature macro: MEMWB_FWD_EN adds a combinational forwarding search
// over all stages through the fwd_* ports.
module memwb_pipe #(
  parameter int DATA_W    = 32,
  parameter int REG_W     = 5,
  parameter int DEPTH     = 1,
  parameter int ZERO_PROT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              i_valid,
  input  logic [1:0]        i_wb,
  input  logic [DATA_W-1:0] i_readdata,
  input  logic [DATA_W-1:0] i_aluresult,
  input  logic [REG_W-1:0]  i_dirwritereg,
`ifdef MEMWB_FWD_EN
  input  logic [REG_W-1:0]  fwd_rs,
  input  logic [REG_W-1:0]  fwd_rt,
  output logic              fwd_hit_rs,
  output logic              fwd_hit_rt,
  output logic [DATA_W-1:0] fwd_data_rs,
  output logic [DATA_W-1:0] fwd_data_rt,
`endif
  output logic              o_valid,
  output logic              o_memtoreg,
  output logic              o_regwrite,
  output logic [DATA_W-1:0] o_readdata,
  output logic [DATA_W-1:0] o_aluresult,
  output logic [REG_W-1:0]  o_dirwritereg,
  output logic [DATA_W-1:0] o_writedata
);

  // Only 1..4 stages are meaningful; anything else stops elaboration.
  generate
    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
      $error("memwb_pipe: DEPTH must be in 1..4");
    end
  endgenerate

  // One pipeline slot: control bits plus the data carried to write-back.
  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              memtoreg;
    logic [DATA_W-1:0] readdata;
    logic [DATA_W-1:0] aluresult;
    logic [REG_W-1:0]  addr;
  } stage_t;

  // stg[0] is the youngest entry (just captured from MEM), stg[DEPTH-1] feeds WB.
  stage_t stg [DEPTH];
  stage_t stg_in;
  stage_t last;

  // Write-back mux for any stage: memory data for loads, ALU result otherwise.
  function automatic logic [DATA_W-1:0] stage_wdata(input stage_t s);
    return s.memtoreg ? s.readdata : s.aluresult;
  endfunction

  // Build the stage-0 capture value; a bubble never carries a write enable.
  always_comb begin
    stg_in.valid     = i_valid;
    stg_in.regwrite  = i_valid & i_wb[1];
    stg_in.memtoreg  = i_wb[0];
    stg_in.readdata  = i_readdata;
    stg_in.aluresult = i_aluresult;
    stg_in.addr      = i_dirwritereg;
  end

  // Stage registers: reset clears, flush invalidates, stall holds, else shift.
  // NOTE: every stage (data fields included) is cleared on reset so all outputs
  // read zero during reset; this is a small register chain, not a RAM, so the
  // reset costs nothing and keeps o_writedata deterministic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        stg[k] <= '0;
      end
    end else if (flush) begin
      // Data fields keep their old contents; only the control that matters is killed.
      for (int k = 0; k < DEPTH; k++) begin
        stg[k].valid    <= 1'b0;
        stg[k].regwrite <= 1'b0;
      end
    end else if (!stall) begin
      // NOTE: non-blocking assignments let every stage read its neighbour's
      // pre-edge value, so the loop order does not matter.
      stg[0] <= stg_in;
      for (int k = 1; k < DEPTH; k++) begin
        stg[k] <= stg[k-1];
      end
    end
  end

  // WB-side outputs decoded straight from the oldest stage.
  always_comb begin
    last          = stg[DEPTH-1];
    o_valid       = last.valid;
    o_memtoreg    = last.memtoreg;
    o_readdata    = last.readdata;
    o_aluresult   = last.aluresult;
    o_dirwritereg = last.addr;
    o_writedata   = stage_wdata(last);
    o_regwrite    = last.valid & last.regwrite &
                    ((ZERO_PROT == 0) || (last.addr != '0));
  end

`ifdef MEMWB_FWD_EN
  // A stage can forward when it will really write a non-$zero register.
  function automatic logic stage_hit(input stage_t s, input logic [REG_W-1:0] r);
    return s.valid & s.regwrite & (s.addr == r) & (s.addr != '0);
  endfunction

  // Forwarding search: scan oldest to youngest so the youngest match overrides.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch forms.
    fwd_hit_rs  = 1'b0;
    fwd_hit_rt  = 1'b0;
    fwd_data_rs = '0;
    fwd_data_rt = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (stage_hit(stg[k], fwd_rs)) begin
        fwd_hit_rs  = 1'b1;
        fwd_data_rs = stage_wdata(stg[k]);
      end
      if (stage_hit(stg[k], fwd_rt)) begin
        fwd_hit_rt  = 1'b1;
        fwd_data_rt = stage_wdata(stg[k]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_memwb_pipe.sv
// tb_memwb_pipe: directed bench for memwb_pipe. A table of single-stage
// vectors plus hand-written multi-cycle sequences on deeper instances.
module tb_memwb_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, i_valid;
  logic [1:0]  i_wb;
  logic [31:0] i_readdata, i_aluresult;
  logic [4:0]  i_dirwritereg;

  // DEPTH=1, ZERO_PROT=1
  logic        v1, m1, rw1;
  logic [31:0] rd1, alu1, wd1;
  logic [4:0]  a1;
  // DEPTH=3, ZERO_PROT=1
  logic        v3, m3, rw3;
  logic [31:0] rd3, alu3, wd3;
  logic [4:0]  a3;
  // DEPTH=1, ZERO_PROT=0
  logic        vz, mz, rwz;
  logic [31:0] rdz, aluz, wdz;
  logic [4:0]  az;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

`ifdef MEMWB_FWD_EN
  logic [4:0]  fwd_rs, fwd_rt;
  logic        h1s, h1t, h3s, h3t, hzs, hzt, h2s, h2t;
  logic [31:0] d1s, d1t, d3s, d3t, dzs, dzt, d2s, d2t;
  logic        v2, m2, rw2;
  logic [31:0] rd2, alu2, wd2;
  logic [4:0]  a2;
`endif

  memwb_pipe #(.DEPTH(1), .ZERO_PROT(1)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .i_valid(i_valid),
    .i_wb(i_wb), .i_readdata(i_readdata), .i_aluresult(i_aluresult),
    .i_dirwritereg(i_dirwritereg),
`ifdef MEMWB_FWD_EN
    .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .fwd_hit_rs(h1s), .fwd_hit_rt(h1t),
    .fwd_data_rs(d1s), .fwd_data_rt(d1t),
`endif
    .o_valid(v1), .o_memtoreg(m1), .o_regwrite(rw1), .o_readdata(rd1),
    .o_aluresult(alu1), .o_dirwritereg(a1), .o_writedata(wd1));

  memwb_pipe #(.DEPTH(3), .ZERO_PROT(1)) dut3 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .i_valid(i_valid),
    .i_wb(i_wb), .i_readdata(i_readdata), .i_aluresult(i_aluresult),
    .i_dirwritereg(i_dirwritereg),
`ifdef MEMWB_FWD_EN
    .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .fwd_hit_rs(h3s), .fwd_hit_rt(h3t),
    .fwd_data_rs(d3s), .fwd_data_rt(d3t),
`endif
    .o_valid(v3), .o_memtoreg(m3), .o_regwrite(rw3), .o_readdata(rd3),
    .o_aluresult(alu3), .o_dirwritereg(a3), .o_writedata(wd3));

  memwb_pipe #(.DEPTH(1), .ZERO_PROT(0)) dutz (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .i_valid(i_valid),
    .i_wb(i_wb), .i_readdata(i_readdata), .i_aluresult(i_aluresult),
    .i_dirwritereg(i_dirwritereg),
`ifdef MEMWB_FWD_EN
    .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .fwd_hit_rs(hzs), .fwd_hit_rt(hzt),
    .fwd_data_rs(dzs), .fwd_data_rt(dzt),
`endif
    .o_valid(vz), .o_memtoreg(mz), .o_regwrite(rwz), .o_readdata(rdz),
    .o_aluresult(aluz), .o_dirwritereg(az), .o_writedata(wdz));

`ifdef MEMWB_FWD_EN
  memwb_pipe #(.DEPTH(2), .ZERO_PROT(1)) dut2 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .i_valid(i_valid),
    .i_wb(i_wb), .i_readdata(i_readdata), .i_aluresult(i_aluresult),
    .i_dirwritereg(i_dirwritereg),
    .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .fwd_hit_rs(h2s), .fwd_hit_rt(h2t),
    .fwd_data_rs(d2s), .fwd_data_rt(d2t),
    .o_valid(v2), .o_memtoreg(m2), .o_regwrite(rw2), .o_readdata(rd2),
    .o_aluresult(alu2), .o_dirwritereg(a2), .o_writedata(wd2));
`endif

  typedef struct {
    logic        stall, flush, valid;
    logic [1:0]  wb;
    logic [31:0] rd, alu;
    logic [4:0]  addr;
    logic        e_valid, e_m2r, e_rw, e_zrw;
    logic [31:0] e_wd;
    logic [4:0]  e_addr;
    bit          chk_data;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic fl, input logic v, input logic [1:0] wb,
                       input logic [31:0] rd, input logic [31:0] alu, input logic [4:0] addr);
    stall = st; flush = fl; i_valid = v; i_wb = wb;
    i_readdata = rd; i_aluresult = alu; i_dirwritereg = addr;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bubble();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Rows: stall flush valid wb rd alu addr | valid m2r rw zrw wd addr chk_data
    vecs[0] = '{1'b0, 1'b0, 1'b1, 2'b10, 32'h0000AAAA, 32'h00001234, 5'd5,
                1'b1, 1'b0, 1'b1, 1'b1, 32'h00001234, 5'd5, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 2'b11, 32'hDEADBEEF, 32'h00000010, 5'd9,
                1'b1, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 5'd9, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 2'b10, 32'h00000001, 32'h00005555, 5'd3,
                1'b1, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 5'd9, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 2'b10, 32'h0000FFFF, 32'h00000077, 5'd0,
                1'b1, 1'b0, 1'b0, 1'b1, 32'h00000077, 5'd0, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 2'b10, 32'h00000000, 32'h00000088, 5'd4,
                1'b0, 1'b0, 1'b0, 1'b0, 32'h00000088, 5'd4, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 2'b01, 32'h00000042, 32'h00000099, 5'd6,
                1'b1, 1'b1, 1'b0, 1'b0, 32'h00000042, 5'd6, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 2'b10, 32'h00000000, 32'h00000100, 5'd8,
                1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 5'd0, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 2'b10, 32'h00000000, 32'h0000CAFE, 5'd31,
                1'b1, 1'b0, 1'b1, 1'b1, 32'h0000CAFE, 5'd31, 1'b1};

`ifdef MEMWB_FWD_EN
    fwd_rs = 5'd0;
    fwd_rt = 5'd0;
`endif

    // Reset with nonzero inputs and a running clock: everything reads zero.
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31);
    tick();
    tick();
    check("rst_valid1", {31'd0, v1}, 32'd0);
    check("rst_rw1", {31'd0, rw1}, 32'd0);
    check("rst_m2r1", {31'd0, m1}, 32'd0);
    check("rst_wd1", wd1, 32'd0);
    check("rst_rd1", rd1, 32'd0);
    check("rst_alu1", alu1, 32'd0);
    check("rst_addr1", {27'd0, a1}, 32'd0);
    check("rst_valid3", {31'd0, v3}, 32'd0);
    check("rst_wd3", wd3, 32'd0);
    check("rst_rwz", {31'd0, rwz}, 32'd0);
    rst = 1'b0;

    // Table phase on the single-stage instances.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].stall, vecs[i].flush, vecs[i].valid, vecs[i].wb,
            vecs[i].rd, vecs[i].alu, vecs[i].addr);
      tick();
      check($sformatf("v%0d_valid", i), {31'd0, v1}, {31'd0, vecs[i].e_valid});
      check($sformatf("v%0d_rw", i), {31'd0, rw1}, {31'd0, vecs[i].e_rw});
      check($sformatf("v%0d_rw_noprot", i), {31'd0, rwz}, {31'd0, vecs[i].e_zrw});
      if (vecs[i].chk_data) begin
        check($sformatf("v%0d_m2r", i), {31'd0, m1}, {31'd0, vecs[i].e_m2r});
        check($sformatf("v%0d_wd", i), wd1, vecs[i].e_wd);
        check($sformatf("v%0d_addr", i), {27'd0, a1}, {27'd0, vecs[i].e_addr});
      end
    end

    // Async reset mid-operation: outputs clear before any clock edge.
    drive(1'b0, 1'b0, 1'b1, 2'b10, 32'h0, 32'h00000060, 5'd8);
    tick();
    check("pre_rst_rw", {31'd0, rw1}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, v1}, 32'd0);
    check("async_rst_rw", {31'd0, rw1}, 32'd0);
    check("async_rst_wd", wd1, 32'd0);
    bubble();
    tick();
    rst = 1'b0;

    // Latency on DEPTH=3: sampled at edge 1, visible after edge 3.
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 2'b10, 32'h0, 32'h00001234, 5'd5);
    tick();
    check("lat_e1_valid", {31'd0, v3}, 32'd0);
    bubble();
    tick();
    check("lat_e2_valid", {31'd0, v3}, 32'd0);
    tick();
    check("lat_e3_rw", {31'd0, rw3}, 32'd1);
    check("lat_e3_wd", wd3, 32'h00001234);
    check("lat_e3_addr", {27'd0, a3}, 32'd5);
    tick();
    check("lat_e4_valid", {31'd0, v3}, 32'd0);

    // Stream A,B,C with stalls: no duplicate and no lost instruction.
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 2'b10, 32'h0, 32'h000000A1, 5'd1);
    tick();
    drive(1'b0, 1'b0, 1'b1, 2'b10, 32'h0, 32'h000000B2, 5'd2);
    tick();
    drive(1'b1, 1'b0, 1'b1, 2'b10, 32'h0, 32'h000000C3, 5'd3);
    tick();
    check("st_e3_valid", {31'd0, v3}, 32'd0);
    tick();
    check("st_e4_valid", {31'd0, v3}, 32'd0);
    stall = 1'b0;
    tick();
    check("st_A_wd", wd3, 32'h000000A1);
    check("st_A_addr", {27'd0, a3}, 32'd1);
    bubble();
    stall = 1'b1;
    tick();
    check("st_A_hold_wd", wd3, 32'h000000A1);
    check("st_A_hold_valid", {31'd0, v3}, 32'd1);
    stall = 1'b0;
    tick();
    check("st_B_wd", wd3, 32'h000000B2);
    check("st_B_valid", {31'd0, v3}, 32'd1);
    tick();
    check("st_C_wd", wd3, 32'h000000C3);
    check("st_C_rw", {31'd0, rw3}, 32'd1);
    tick();
    check("st_after_C_valid", {31'd0, v3}, 32'd0);
    tick();
    check("st_after_C2_valid", {31'd0, v3}, 32'd0);

    // Flush and stall together with two in flight: pipeline empties, then resumes.
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 2'b10, 32'h0, 32'h00000051, 5'd4);
    tick();
    drive(1'b0, 1'b0, 1'b1, 2'b10, 32'h0, 32'h00000052, 5'd6);
    tick();
    drive(1'b1, 1'b1, 1'b1, 2'b10, 32'h0, 32'h00000053, 5'd7);
    tick();
    check("fl_valid", {31'd0, v3}, 32'd0);
    check("fl_rw", {31'd0, rw3}, 32'd0);
    bubble();
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("fl_drain%0d_valid", i), {31'd0, v3}, 32'd0);
    end
    drive(1'b0, 1'b0, 1'b1, 2'b10, 32'h0, 32'h00000053, 5'd7);
    tick();
    bubble();
    tick();
    tick();
    check("fl_resume_valid", {31'd0, v3}, 32'd1);
    check("fl_resume_wd", wd3, 32'h00000053);

`ifdef MEMWB_FWD_EN
    // Forwarding: youngest matching stage wins; register 0 never hits.
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 2'b10, 32'h0, 32'h0000000B, 5'd7);
    tick();
    drive(1'b0, 1'b0, 1'b1, 2'b10, 32'h0, 32'h0000000A, 5'd7);
    tick();
    bubble();
    fwd_rs = 5'd7;
    fwd_rt = 5'd0;
    #1;
    check("fwd_hit_rs", {31'd0, h2s}, 32'd1);
    check("fwd_data_rs", d2s, 32'h0000000A);
    check("fwd_hit_rt", {31'd0, h2t}, 32'd0);
    check("fwd_data_rt", d2t, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
